// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder for the core's
// load/store port. Stores are steered into byte lanes and committed with a
// byte enable; loads return the whole aligned 32-bit word. A programmable
// number of wait states sits between request accept and response.
//
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
//   defined   : illegal-size or misaligned requests complete with rsp_err_o=1,
//               stores write nothing and loads return 0.
//   undefined : rsp_err_o is always 0; misaligned halves use adr[1] only,
//               misaligned words ignore adr[1:0], a non-one-hot size uses its
//               highest set bit and size 0 behaves as a byte.
//
// Handshake semantics (both channels): a transfer happens on a rising edge
// where valid and ready are both high. req_ready_o depends only on the FSM
// state (high in IDLE). Once rsp_valid_o is high, rsp_rdata_o and rsp_err_o
// stay stable until the edge where rsp_ready_i is sampled high.

module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0,
    localparam int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [XLEN-1:0] req_adr_i,
    input  logic [2:0]      req_size_i,
    input  logic [XLEN-1:0] req_wdata_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [XLEN-1:0] rsp_rdata_o,
    output logic            rsp_err_o,
    output logic [1:0]      dbg_state_o
);

    // Word-index width; the array wraps modulo DEPTH_WORDS.
    localparam int AW = $clog2(DEPTH_WORDS);

    // Value loaded into the wait counter on accept (counts down to 0 in WAIT).
    localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Decoded view of the incoming request
    logic            dec_word;
    logic            dec_half;
    logic [3:0]      dec_be;
    logic [XLEN-1:0] dec_wdata;
    logic            dec_err;
    logic [AW-1:0]   dec_idx;

    // Request captured at accept
    logic            q_we;
    logic [AW-1:0]   q_idx;
    logic [3:0]      q_be;
    logic [XLEN-1:0] q_wdata;
    logic            q_err;
    logic [3:0]      cnt;

    // Access that commits on the current edge (request path or captured path)
    logic            commit;
    logic            cur_we;
    logic [AW-1:0]   cur_idx;
    logic [3:0]      cur_be;
    logic [XLEN-1:0] cur_wdata;
    logic            cur_err;

    // Response registers
    logic [XLEN-1:0] rdata_q;
    logic            err_q;

    logic            accept;

    // Word storage; intentionally not reset.
    logic [XLEN-1:0] mem [DEPTH_WORDS];

    // Upper address bits above the word index play no part in addressing.
    logic            unused_adr_hi;
    assign unused_adr_hi = ^req_adr_i[XLEN-1:AW+2];

    assign dec_idx = req_adr_i[AW+1:2];
    assign accept  = (state == S_IDLE) && req_valid_i;

    // Effective access size: highest set bit of the size field wins, 0 is a byte.
    always_comb begin
        dec_word = req_size_i[2];
        dec_half = !req_size_i[2] && req_size_i[1];
    end

    // Store lane steering: replicate the right-justified data, pick the byte enable.
    always_comb begin
        dec_be    = 4'b0000;
        dec_wdata = req_wdata_i;
        if (dec_word) begin
            dec_be    = 4'b1111;
            dec_wdata = req_wdata_i;
        end else if (dec_half) begin
            dec_be    = 4'b0011 << {req_adr_i[1], 1'b0};
            dec_wdata = {2{req_wdata_i[15:0]}};
        end else begin
            dec_be    = 4'b0001 << req_adr_i[1:0];
            dec_wdata = {4{req_wdata_i[7:0]}};
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    // Error detection: non-one-hot size, odd half address, or unaligned word.
    always_comb begin
        dec_err = 1'b0;
        if ((req_size_i != 3'b001) && (req_size_i != 3'b010) && (req_size_i != 3'b100)) begin
            dec_err = 1'b1;
        end else if ((req_size_i == 3'b010) && req_adr_i[0]) begin
            dec_err = 1'b1;
        end else if ((req_size_i == 3'b100) && (req_adr_i[1:0] != 2'b00)) begin
            dec_err = 1'b1;
        end
    end
`else
    assign dec_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_valid_i) begin
                    state_nxt = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs that depend only on state.
    always_comb begin
        req_ready_o = (state == S_IDLE);
        rsp_valid_o = (state == S_RESP);
        dbg_state_o = state;
        rsp_rdata_o = rdata_q;
        rsp_err_o   = err_q;
    end

    // Capture the decoded request on accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_we    <= 1'b0;
            q_idx   <= '0;
            q_be    <= 4'b0000;
            q_wdata <= '0;
            q_err   <= 1'b0;
        end else if (accept) begin
            q_we    <= req_we_i;
            q_idx   <= dec_idx;
            q_be    <= dec_be;
            q_wdata <= dec_wdata;
            q_err   <= dec_err;
        end
    end

    // Wait-state counter: loaded on accept, counts down while in WAIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= 4'd0;
        end else if (accept) begin
            cnt <= CNT_INIT;
        end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Select the access that commits this edge: with no wait states the
    // request commits straight from the ports, otherwise from the captured copy.
    always_comb begin
        commit    = 1'b0;
        cur_we    = q_we;
        cur_idx   = q_idx;
        cur_be    = q_be;
        cur_wdata = q_wdata;
        cur_err   = q_err;
        case (state)
            S_IDLE: begin
                if (req_valid_i && (WAIT_STATES == 0)) begin
                    commit    = 1'b1;
                    cur_we    = req_we_i;
                    cur_idx   = dec_idx;
                    cur_be    = dec_be;
                    cur_wdata = dec_wdata;
                    cur_err   = dec_err;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    commit = 1'b1;
                end
            end
            default: commit = 1'b0;
        endcase
    end

    // Byte-enabled store into the array on the commit edge; errored stores write nothing.
    always_ff @(posedge clk) begin
        if (commit && cur_we && !cur_err) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_be[b]) begin
                    mem[cur_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
                end
            end
        end
    end

    // Response data: load word or 0 latched on the commit edge, cleared when the response is taken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (commit) begin
            err_q   <= cur_err;
            rdata_q <= (cur_we || cur_err) ? '0 : mem[cur_idx];
        end else if ((state == S_RESP) && rsp_ready_i) begin
            err_q   <= 1'b0;
            rdata_q <= '0;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (0 and 3 wait states) driven
// through a shared access task; a reference word model feeds an expected
// queue that is compared whenever a response appears.
module tb_dmem_responder;
  localparam int WS0 = 0;
  localparam int WS1 = 3;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        req_valid[2];
  logic        req_ready[2];
  logic        req_we[2];
  logic [31:0] req_adr[2];
  logic [2:0]  req_size[2];
  logic [31:0] req_wdata[2];
  logic        rsp_valid[2];
  logic        rsp_ready[2];
  logic [31:0] rsp_rdata[2];
  logic        rsp_err[2];
  logic [1:0]  dbg_state[2];

  int pass_cnt = 0;
  int check_cnt = 0;

  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  logic [31:0] model_mem[2][1024];

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(WS0)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we[0]),
    .req_adr_i(req_adr[0]), .req_size_i(req_size[0]), .req_wdata_i(req_wdata[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]), .rsp_rdata_o(rsp_rdata[0]),
    .rsp_err_o(rsp_err[0]), .dbg_state_o(dbg_state[0])
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(WS1)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we[1]),
    .req_adr_i(req_adr[1]), .req_size_i(req_size[1]), .req_wdata_i(req_wdata[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]), .rsp_rdata_o(rsp_rdata[1]),
    .rsp_err_o(rsp_err[1]), .dbg_state_o(dbg_state[1])
  );

  // Reference model: applies a request to the word model, pushes the expected response.
  function automatic void model_access(input int d, input logic we, input logic [31:0] adr,
                                       input logic [2:0] size, input logic [31:0] wdata);
    int idx;
    int k;
    int h;
    logic err;
    idx = int'(adr[11:2]);
    k = int'(adr[1:0]);
    h = adr[1] ? 16 : 0;
`ifdef DMEM_MISALIGN_TRAP_EN
    err = !(size == 3'b001 || size == 3'b010 || size == 3'b100) ||
          (size == 3'b010 && adr[0]) || (size == 3'b100 && adr[1:0] != 2'b00);
`else
    err = 1'b0;
`endif
    if (we && !err) begin
      if (size[2]) model_mem[d][idx] = wdata;
      else if (size[1]) model_mem[d][idx][h +: 16] = wdata[15:0];
      else model_mem[d][idx][8*k +: 8] = wdata[7:0];
    end
    exp_q.push_back((we || err) ? 32'h0 : model_mem[d][idx]);
    exp_err_q.push_back(err);
  endfunction

  // Driver + scoreboard: one access on instance d, optional backpressure of 'hold' cycles.
  task automatic do_access(input int d, input logic we, input logic [31:0] adr,
                           input logic [2:0] size, input logic [31:0] wdata, input int hold);
    int lat;
    int ws;
    logic [31:0] exp_r;
    logic exp_e;
    ws = (d == 0) ? WS0 : WS1;
    model_access(d, we, adr, size, wdata);
    @(negedge clk);
    check_cnt++;
    if (req_ready[d] !== 1'b1)
      $display("FAIL req_ready_idle dut%0d: got %b want 1", d, req_ready[d]);
    else pass_cnt++;
    req_valid[d] = 1'b1; req_we[d] = we; req_adr[d] = adr;
    req_size[d] = size; req_wdata[d] = wdata; rsp_ready[d] = 1'b0;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    req_wdata[d] = $urandom;
    req_adr[d] = $urandom;
    lat = 1;
    while (rsp_valid[d] !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check_cnt++;
    if (lat != 1 + ws)
      $display("FAIL latency dut%0d adr=%h: got %0d cycles want %0d", d, adr, lat, 1 + ws);
    else pass_cnt++;
    exp_r = exp_q.pop_front();
    exp_e = exp_err_q.pop_front();
    check_cnt++;
    if (rsp_rdata[d] !== exp_r)
      $display("FAIL rdata dut%0d we=%b adr=%h size=%b: got %h want %h", d, we, adr, size, rsp_rdata[d], exp_r);
    else pass_cnt++;
    check_cnt++;
    if (rsp_err[d] !== exp_e)
      $display("FAIL err dut%0d adr=%h size=%b: got %b want %b", d, adr, size, rsp_err[d], exp_e);
    else pass_cnt++;
    for (int i = 0; i < hold; i++) begin
      req_valid[d] = 1'b1; req_we[d] = 1'b1; req_adr[d] = adr;
      req_size[d] = 3'b100; req_wdata[d] = 32'hBAD0BAD0;
      @(posedge clk); #1;
      check_cnt++;
      if ({rsp_valid[d], req_ready[d], rsp_err[d], rsp_rdata[d]} !== {1'b1, 1'b0, exp_e, exp_r})
        $display("FAIL hold dut%0d cyc%0d: got v=%b rdy=%b e=%b d=%h want v=1 rdy=0 e=%b d=%h",
                 d, i, rsp_valid[d], req_ready[d], rsp_err[d], rsp_rdata[d], exp_e, exp_r);
      else pass_cnt++;
    end
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    check_cnt++;
    if ({rsp_valid[d], req_ready[d]} !== 2'b01)
      $display("FAIL release dut%0d: got valid=%b ready=%b want valid=0 ready=1", d, rsp_valid[d], req_ready[d]);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    for (int d = 0; d < 2; d++) begin
      check_cnt++;
      if ({req_ready[d], rsp_valid[d], rsp_err[d], rsp_rdata[d]} !== {1'b1, 1'b0, 1'b0, 32'h0})
        $display("FAIL reset_state dut%0d: got rdy=%b v=%b e=%b d=%h want 1 0 0 00000000",
                 d, req_ready[d], rsp_valid[d], rsp_err[d], rsp_rdata[d]);
      else pass_cnt++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      check_cnt++;
      if ({req_ready[d], rsp_valid[d]} !== 2'b10)
        $display("FAIL post_reset dut%0d: got rdy=%b v=%b want 1 0", d, req_ready[d], rsp_valid[d]);
      else pass_cnt++;
    end
  endtask

  task automatic test_basic;
    do_access(0, 1'b1, 32'h10, 3'b100, 32'hDEADBEEF, 0);
    do_access(0, 1'b0, 32'h10, 3'b100, 32'h0, 0);
  endtask

  task automatic test_lanes;
    do_access(0, 1'b1, 32'h10, 3'b100, 32'h11223344, 0);
    do_access(0, 1'b1, 32'h13, 3'b001, 32'h000000A5, 0);
    do_access(0, 1'b0, 32'h10, 3'b100, 32'h0, 0);
    do_access(0, 1'b1, 32'h10, 3'b100, 32'h11223344, 0);
    do_access(0, 1'b1, 32'h12, 3'b010, 32'h0000BEEF, 0);
    do_access(0, 1'b0, 32'h10, 3'b100, 32'h0, 0);
    do_access(0, 1'b1, 32'h11, 3'b001, 32'hFFFFFF5A, 0);
    do_access(0, 1'b1, 32'h10, 3'b010, 32'hFFFF7E7E, 0);
    do_access(0, 1'b0, 32'h11, 3'b001, 32'h0, 0);
  endtask

  task automatic test_wait_states;
    do_access(1, 1'b1, 32'h30, 3'b100, 32'h0BADF00D, 0);
    do_access(1, 1'b0, 32'h30, 3'b100, 32'h0, 5);
    do_access(1, 1'b0, 32'h30, 3'b100, 32'h0, 0);
    do_access(1, 1'b1, 32'h31, 3'b001, 32'h000000C3, 2);
    do_access(1, 1'b0, 32'h30, 3'b100, 32'h0, 0);
  endtask

  task automatic test_misalign;
    do_access(0, 1'b1, 32'h20, 3'b100, 32'h11111111, 0);
    do_access(0, 1'b1, 32'h21, 3'b100, 32'hFFFFFFFF, 0);
    do_access(0, 1'b0, 32'h20, 3'b100, 32'h0, 0);
    do_access(0, 1'b1, 32'h20, 3'b100, 32'h11111111, 0);
    do_access(0, 1'b1, 32'h22, 3'b011, 32'h0000ABCD, 0);
    do_access(0, 1'b0, 32'h20, 3'b100, 32'h0, 0);
    do_access(0, 1'b1, 32'h23, 3'b010, 32'h00007777, 0);
    do_access(0, 1'b0, 32'h20, 3'b000, 32'h0, 0);
    do_access(0, 1'b1, 32'h21, 3'b000, 32'h00000042, 0);
    do_access(0, 1'b0, 32'h23, 3'b110, 32'h0, 0);
    do_access(0, 1'b0, 32'h20, 3'b100, 32'h0, 0);
  endtask

  task automatic test_wrap;
    do_access(0, 1'b1, 32'h1000, 3'b100, 32'h12345678, 0);
    do_access(0, 1'b0, 32'h0000, 3'b100, 32'h0, 0);
    do_access(0, 1'b0, 32'hFFFF_F000, 3'b100, 32'h0, 0);
  endtask

  task automatic test_reset_mid_access;
    do_access(1, 1'b1, 32'h40, 3'b100, 32'hCAFEF00D, 0);
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_adr[1] = 32'h40;
    req_size[1] = 3'b100; req_wdata[1] = 32'h55555555; rsp_ready[1] = 1'b0;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_cnt++;
    if ({rsp_valid[1], req_ready[1]} !== 2'b01)
      $display("FAIL reset_mid_async: got valid=%b ready=%b want 0 1", rsp_valid[1], req_ready[1]);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check_cnt++;
      if ({rsp_valid[1], req_ready[1]} !== 2'b01)
        $display("FAIL reset_mid_after: got valid=%b ready=%b want 0 1", rsp_valid[1], req_ready[1]);
      else pass_cnt++;
    end
    do_access(1, 1'b0, 32'h40, 3'b100, 32'h0, 0);
  endtask

  task automatic test_back_to_back_random;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++)
        do_access(d, 1'b1, 32'h100 + 32'(4 * i), 3'b100, $urandom, 0);
    for (int n = 0; n < 60; n++) begin
      int d;
      logic we;
      logic [31:0] adr;
      logic [2:0] size;
      d = int'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      adr = 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      size = 3'($urandom_range(0, 7));
      do_access(d, we, adr, size, $urandom, int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", pass_cnt, check_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_adr[d] = 32'h0;
      req_size[d] = 3'b000; req_wdata[d] = 32'h0; rsp_ready[d] = 1'b0;
    end
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    test_basic;
    test_lanes;
    test_wait_states;
    test_misalign;
    test_wrap;
    test_reset_mid_access;
    test_back_to_back_random;
    check_cnt++;
    if (exp_q.size() != 0)
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder on the core's load/store port. It accepts one request at a time from the load/store unit: a byte address, a one-hot access size, store data, and a write flag. It performs byte-lane-aligned writes into an internal word array, or returns the full aligned 32-bit word for loads. Lane extraction and sign extension of load data stay in the core. This block only steers store data into lanes and reads whole words, and it inserts a configurable number of wait states.

## Interface
Parameters:
- `DEPTH_WORDS`, default 1024: number of 32-bit words. Must be a power of two, at least 2.
- `WAIT_STATES`, default 0: extra cycles between request accept and response. Range 0..15.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid_i` in 1: request present.
- `req_ready_o` out 1: request can be accepted. High only in IDLE.
- `req_we_i` in 1: 1 = store, 0 = load.
- `req_adr_i` in XLEN: byte address.
- `req_size_i` in 3: one-hot size. bit0 = byte, bit1 = half, bit2 = word.
- `req_wdata_i` in XLEN: store data, right-justified (unshifted).
- `rsp_valid_o` out 1: response present.
- `rsp_ready_i` in 1: core accepts the response.
- `rsp_rdata_o` out XLEN: full aligned word for loads. 0 for stores and for errored loads.
- `rsp_err_o` out 1: misaligned or illegal-size access. Forced to 0 when the macro is off.

## Operation
- Word index is `req_adr_i[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses wrap modulo the array size.
- Store lane steering uses `k = adr[1:0]`:
  - byte: `wdata[7:0]` replicated to all four lanes; byte enable `1<<k`.
  - half: `wdata[15:0]` replicated to both halves; byte enable `4'b0011 << {k[1],1'b0}`.
  - word: `wdata` unchanged; byte enable `4'b1111`.
- Only enabled bytes change. The array is not reset.
- A request is illegal if `req_size_i` is not one-hot.
- A request is misaligned if it is a half with `adr[0]=1`, or a word with `adr[1:0]!=0`.
- FSM states and transitions:
  - IDLE: `req_ready_o=1`. On `req_valid_i & req_ready_o`, register we/index/byte-enable/wdata/err. If `WAIT_STATES=0` go to RESP, else load the counter with `WAIT_STATES-1` and go to WAIT.
  - WAIT: decrement the counter. When it is 0, go to RESP.
  - RESP: `rsp_valid_o=1`. Hold all response outputs stable until `rsp_ready_i`, then go to IDLE.
- A store commits to the array on the WAIT→RESP or IDLE→RESP edge, and only if err=0.
- A load reads the array on that same edge, so `rsp_rdata_o` reflects all earlier stores.
- New requests are never accepted while a response is outstanding; there is no pipelining.

## Timing
- Reset values: state IDLE, `req_ready_o=1`, `rsp_valid_o=0`, `rsp_rdata_o=0`, `rsp_err_o=0`, counter 0.
- Latency: accept at edge N, then `rsp_valid_o` is high from edge N+1+`WAIT_STATES`.
- Peak throughput with `rsp_ready_i` tied high: one access every 2+`WAIT_STATES` cycles. The IDLE cycle follows RESP.
- `req_ready_o` depends only on state. `req_valid_i` may drop without effect while ready is low.
- Reset asserted mid-access: the in-flight request is discarded and returns no response. A store not yet committed does not reach the array. `rsp_valid_o` drops asynchronously.
- Load immediately after a store to the same word returns the post-store value.

## Configuration
- `DMEM_MISALIGN_TRAP_EN`, when defined:
  - Illegal or misaligned requests complete with `rsp_err_o=1`.
  - Stores write nothing; loads return 0.
  - Latency is unchanged.
- When undefined:
  - `rsp_err_o` is tied to 0.
  - Misaligned halves use `adr[1]` only; misaligned words ignore `adr[1:0]`.
  - A non-one-hot size uses the highest set bit, and size 0 is treated as a byte.

## Test plan
- `WAIT_STATES=0`: store word 0xDEADBEEF to 0x10, then load 0x10 → `rsp_rdata_o=0xDEADBEEF`, `rsp_valid_o` one cycle after each accept, `rsp_err_o=0`.
- Byte store 0x000000A5 to 0x13 over word 0x11223344 at 0x10, then load 0x10 → 0xA5223344. Half store 0x0000BEEF to 0x12 over 0x11223344 → 0xBEEF3344.
- `WAIT_STATES=3`: accept at cycle 0 → `rsp_valid_o` rises at cycle 4. Holding `rsp_ready_i=0` for 5 cycles keeps `rsp_valid_o`/`rsp_rdata_o` stable and `req_ready_o=0`.
- Macro defined: word store 0xFFFFFFFF to 0x21 → `rsp_err_o=1`, and a load of 0x20 returns the prior value unchanged. Macro undefined: the same store writes 0xFFFFFFFF at 0x20 with `rsp_err_o=0`.
- `DEPTH_WORDS=1024`: store 0x12345678 to 0x1000, load 0x0000 → 0x12345678 (wrap-around).
- Assert `reset_n=0` during WAIT of a store to 0x40 → `rsp_valid_o=0`, `req_ready_o=1` after release, and a load of 0x40 returns the old contents.
